mem_xfer_control: RTL and testbench



---
 rtl/mem_xfer_control.sv | 201 ++++++++++++++++++++
 tb/tb_mem_xfer_control.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_xfer_control.sv
// Hardwired T-step sequencer for instruction fetch and the ld/ldi/st memory-transfer
// instructions; drives the Datapath control strobes one step per clock.
module mem_xfer_control #(
  parameter logic [4:0] OP_LD     = 5'b00000,
  parameter logic [4:0] OP_LDI    = 5'b00001,
  parameter logic [4:0] OP_ST     = 5'b00010,
  parameter logic [4:0] ALU_ADD   = 5'b00011,
  parameter int         CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 run,
  input  logic [31:0]          IR,
  output logic                 PC_out,
  output logic                 IncPC,
  output logic                 PC_enable,
  output logic                 MAR_enable,
  output logic                 Read,
  output logic                 MDR_enable,
  output logic                 MDR_out,
  output logic                 IR_enable,
  output logic                 Gra,
  output logic                 Grb,
  output logic                 BA_out,
  output logic                 R_in,
  output logic                 Y_enable,
  output logic                 C_out,
  output logic                 Z_enable,
  output logic                 ZLow_out,
  output logic                 RAM_write_enable,
  output logic [4:0]           opcode,
  output logic [2:0]           t_step,
  output logic                 busy,
  output logic                 illegal,
  output logic [CNT_WIDTH-1:0] retired
);

  typedef enum logic [3:0] {
    IDLE, F0, F1, F2, E3, E4, E5, E6, E7
  } state_e;

  state_e               state_q, state_d;
  logic [4:0]           op_q, op_d;
  logic [CNT_WIDTH-1:0] retired_q, retired_d;

  logic [4:0] ir_op;
  logic       ir_legal;
  logic       last_step;

  assign ir_op    = IR[31:27];
  assign ir_legal = (ir_op == OP_LD) || (ir_op == OP_LDI) || (ir_op == OP_ST);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q   <= IDLE;
      op_q      <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      retired_q <= retired_d;
    end
  end

  // Next-state, opcode latch and retire counter.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    last_step = 1'b0;
    unique case (state_q)
      IDLE: if (run) state_d = F0;
      F0:   state_d = F1;
      F1:   state_d = F2;
      F2:   state_d = E3;
      E3: begin
        op_d    = ir_op;
        state_d = ir_legal ? E4 : IDLE;
      end
      E4:   state_d = E5;
      E5: begin
        if (op_q == OP_LDI) begin
          last_step = 1'b1;
          state_d   = run ? F0 : IDLE;
        end else begin
          state_d = E6;
        end
      end
      E6:   state_d = E7;
      E7: begin
        last_step = 1'b1;
        state_d   = run ? F0 : IDLE;
      end
      default: state_d = IDLE;
    endcase
    retired_d = last_step ? retired_q + 1'b1 : retired_q;
  end

  // Strobes depend on the state register only, except E3 which is
  // suppressed when the freshly loaded IR holds an unsupported opcode.
  always_comb begin
    PC_out           = 1'b0;
    IncPC            = 1'b0;
    PC_enable        = 1'b0;
    MAR_enable       = 1'b0;
    Read             = 1'b0;
    MDR_enable       = 1'b0;
    MDR_out          = 1'b0;
    IR_enable        = 1'b0;
    Gra              = 1'b0;
    Grb              = 1'b0;
    BA_out           = 1'b0;
    R_in             = 1'b0;
    Y_enable         = 1'b0;
    C_out            = 1'b0;
    Z_enable         = 1'b0;
    ZLow_out         = 1'b0;
    RAM_write_enable = 1'b0;
    opcode           = '0;
    illegal          = 1'b0;
    unique case (state_q)
      IDLE: ;
      F0: begin
        PC_out     = 1'b1;
        MAR_enable = 1'b1;
        IncPC      = 1'b1;
        PC_enable  = 1'b1;
      end
      F1: begin
        Read       = 1'b1;
        MDR_enable = 1'b1;
      end
      F2: begin
        MDR_out   = 1'b1;
        IR_enable = 1'b1;
      end
      E3: begin
        if (ir_legal) begin
          Grb      = 1'b1;
          BA_out   = 1'b1;
          Y_enable = 1'b1;
        end else begin
          illegal = 1'b1;
        end
      end
      E4: begin
        C_out    = 1'b1;
        Z_enable = 1'b1;
        opcode   = ALU_ADD;
      end
      E5: begin
        ZLow_out = 1'b1;
        if (op_q == OP_LDI) begin
          Gra  = 1'b1;
          R_in = 1'b1;
        end else begin
          MAR_enable = 1'b1;
        end
      end
      E6: begin
        MDR_enable = 1'b1;
        if (op_q == OP_LD) begin
          Read = 1'b1;
        end else begin
          Gra    = 1'b1;
          BA_out = 1'b1;
        end
      end
      E7: begin
        MDR_out = 1'b1;
        if (op_q == OP_LD) begin
          Gra  = 1'b1;
          R_in = 1'b1;
        end else begin
          RAM_write_enable = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    unique case (state_q)
      F0:      t_step = 3'd0;
      F1:      t_step = 3'd1;
      F2:      t_step = 3'd2;
      E3:      t_step = 3'd3;
      E4:      t_step = 3'd4;
      E5:      t_step = 3'd5;
      E6:      t_step = 3'd6;
      E7:      t_step = 3'd7;
      default: t_step = 3'd0;
    endcase
  end

  assign busy    = (state_q != IDLE);
  assign retired = retired_q;

endmodule

// File: tb/tb_mem_xfer_control.sv
// Directed bench for mem_xfer_control: per-cycle vector table plus hand-written
// reset-abort and counter-wrap sequences.
module tb_mem_xfer_control;

  localparam logic [16:0] PCO  = 17'h10000, INC  = 17'h08000, PCE = 17'h04000,
                          MARE = 17'h02000, RD   = 17'h01000, MDRE = 17'h00800,
                          MDRO = 17'h00400, IRE  = 17'h00200, GRA = 17'h00100,
                          GRB  = 17'h00080, BAO  = 17'h00040, RIN = 17'h00020,
                          YE   = 17'h00010, CO   = 17'h00008, ZE  = 17'h00004,
                          ZLO  = 17'h00002, RAMW = 17'h00001;
  localparam logic [4:0] LD = 5'b00000, LDI = 5'b00001, ST = 5'b00010, BAD = 5'b11111;

  logic        clk, clr, run;
  logic [31:0] IR;
  logic PC_out, IncPC, PC_enable, MAR_enable, Read, MDR_enable, MDR_out, IR_enable;
  logic Gra, Grb, BA_out, R_in, Y_enable, C_out, Z_enable, ZLow_out, RAM_write_enable;
  logic [4:0]  opcode;
  logic [2:0]  t_step;
  logic        busy, illegal;
  logic [15:0] retired;

  logic [16:0] s2;
  logic [4:0]  opcode2;
  logic [2:0]  t_step2;
  logic        busy2, illegal2;
  logic [1:0]  retired2;

  int n_checks = 0;
  int n_fail   = 0;

  mem_xfer_control dut (
    .clk(clk), .clr(clr), .run(run), .IR(IR),
    .PC_out(PC_out), .IncPC(IncPC), .PC_enable(PC_enable), .MAR_enable(MAR_enable),
    .Read(Read), .MDR_enable(MDR_enable), .MDR_out(MDR_out), .IR_enable(IR_enable),
    .Gra(Gra), .Grb(Grb), .BA_out(BA_out), .R_in(R_in), .Y_enable(Y_enable),
    .C_out(C_out), .Z_enable(Z_enable), .ZLow_out(ZLow_out),
    .RAM_write_enable(RAM_write_enable), .opcode(opcode), .t_step(t_step),
    .busy(busy), .illegal(illegal), .retired(retired)
  );

  // Narrow-counter copy sharing all inputs, used to observe wrap-around.
  mem_xfer_control #(.CNT_WIDTH(2)) dut_w2 (
    .clk(clk), .clr(clr), .run(run), .IR(IR),
    .PC_out(s2[16]), .IncPC(s2[15]), .PC_enable(s2[14]), .MAR_enable(s2[13]),
    .Read(s2[12]), .MDR_enable(s2[11]), .MDR_out(s2[10]), .IR_enable(s2[9]),
    .Gra(s2[8]), .Grb(s2[7]), .BA_out(s2[6]), .R_in(s2[5]), .Y_enable(s2[4]),
    .C_out(s2[3]), .Z_enable(s2[2]), .ZLow_out(s2[1]),
    .RAM_write_enable(s2[0]), .opcode(opcode2), .t_step(t_step2),
    .busy(busy2), .illegal(illegal2), .retired(retired2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        run;
    logic [4:0]  op;
    logic [16:0] strobes;
    logic [4:0]  opc;
    logic [2:0]  t;
    logic        busy;
    logic        ill;
    logic [15:0] ret;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [16:0] strobes_now();
    return {PC_out, IncPC, PC_enable, MAR_enable, Read, MDR_enable, MDR_out, IR_enable,
            Gra, Grb, BA_out, R_in, Y_enable, C_out, Z_enable, ZLow_out, RAM_write_enable};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_inv(input string tag);
    int drivers;
    drivers = int'(PC_out) + int'(MDR_out) + int'(BA_out) + int'(C_out) + int'(ZLow_out);
    check({tag, " bus_drivers<=1"}, 32'(drivers <= 1), 32'd1);
    check({tag, " read_write_excl"}, 32'(Read && RAM_write_enable), 32'd0);
  endtask

  task automatic add(input logic r, input logic [4:0] op, input logic [16:0] s,
                     input logic [4:0] opc, input logic [2:0] t, input logic b,
                     input logic il, input logic [15:0] ret);
    vec_t v;
    v.run = r; v.op = op; v.strobes = s; v.opc = opc; v.t = t;
    v.busy = b; v.ill = il; v.ret = ret;
    vecs.push_back(v);
  endtask

  task automatic do_reset();
    @(negedge clk);
    clr = 1'b1;
    run = 1'b0;
    @(negedge clk);
    @(negedge clk);
    clr = 1'b0;
  endtask

  initial begin
    bit found;
    clr = 1'b1;
    run = 1'b0;
    IR  = 32'h0;

    // Reset and idle hold.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      #1;
      check($sformatf("idle%0d strobes", i), 32'(strobes_now()), 32'd0);
      check($sformatf("idle%0d busy_t", i), {28'd0, busy, t_step}, 32'd0);
      check($sformatf("idle%0d retired", i), 32'(retired), 32'd0);
      @(negedge clk);
    end

    // Reset during E6 of st: no write strobe may ever appear.
    IR  = {ST, 27'h0A5A5A5};
    run = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      #1;
      check_inv($sformatf("abort%0d", i));
      check($sformatf("abort%0d ramw", i), 32'(RAM_write_enable), 32'd0);
      if (t_step == 3'd6) found = 1'b1;
    end
    check("abort reached_E6", 32'(found), 32'd1);
    clr = 1'b1;
    run = 1'b0;
    @(negedge clk);
    #1;
    clr = 1'b0;
    check("abort strobes", 32'(strobes_now()), 32'd0);
    check("abort busy", 32'(busy), 32'd0);
    check("abort retired", 32'(retired), 32'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      check($sformatf("post_abort%0d ramw_busy", i), {30'd0, RAM_write_enable, busy}, 32'd0);
    end

    // Per-cycle table: st, ld+ldi back-to-back (IR swapped mid-ld), illegal opcode.
    add(1, ST,  '0,                    0, 0, 0, 0, 0);
    add(1, ST,  PCO|MARE|INC|PCE,      0, 0, 1, 0, 0);
    add(1, ST,  RD|MDRE,               0, 1, 1, 0, 0);
    add(1, ST,  MDRO|IRE,              0, 2, 1, 0, 0);
    add(1, ST,  GRB|BAO|YE,            0, 3, 1, 0, 0);
    add(1, ST,  CO|ZE,             5'd3, 4, 1, 0, 0);
    add(1, ST,  ZLO|MARE,              0, 5, 1, 0, 0);
    add(1, ST,  GRA|BAO|MDRE,          0, 6, 1, 0, 0);
    add(0, ST,  MDRO|RAMW,             0, 7, 1, 0, 0);
    add(0, ST,  '0,                    0, 0, 0, 0, 1);
    add(1, LD,  '0,                    0, 0, 0, 0, 1);
    add(1, LD,  PCO|MARE|INC|PCE,      0, 0, 1, 0, 1);
    add(1, LD,  RD|MDRE,               0, 1, 1, 0, 1);
    add(1, LD,  MDRO|IRE,              0, 2, 1, 0, 1);
    add(1, LD,  GRB|BAO|YE,            0, 3, 1, 0, 1);
    add(1, LD,  CO|ZE,             5'd3, 4, 1, 0, 1);
    add(1, LDI, ZLO|MARE,              0, 5, 1, 0, 1);
    add(1, LDI, RD|MDRE,               0, 6, 1, 0, 1);
    add(1, LDI, MDRO|GRA|RIN,          0, 7, 1, 0, 1);
    add(1, LDI, PCO|MARE|INC|PCE,      0, 0, 1, 0, 2);
    add(1, LDI, RD|MDRE,               0, 1, 1, 0, 2);
    add(1, LDI, MDRO|IRE,              0, 2, 1, 0, 2);
    add(1, LDI, GRB|BAO|YE,            0, 3, 1, 0, 2);
    add(1, LDI, CO|ZE,             5'd3, 4, 1, 0, 2);
    add(0, LDI, ZLO|GRA|RIN,           0, 5, 1, 0, 2);
    add(0, LDI, '0,                    0, 0, 0, 0, 3);
    add(1, BAD, '0,                    0, 0, 0, 0, 3);
    add(1, BAD, PCO|MARE|INC|PCE,      0, 0, 1, 0, 3);
    add(1, BAD, RD|MDRE,               0, 1, 1, 0, 3);
    add(1, BAD, MDRO|IRE,              0, 2, 1, 0, 3);
    add(1, BAD, '0,                    0, 3, 1, 1, 3);
    add(0, BAD, '0,                    0, 0, 0, 0, 3);
    add(0, BAD, '0,                    0, 0, 0, 0, 3);

    do_reset();
    foreach (vecs[i]) begin
      run = vecs[i].run;
      IR  = {vecs[i].op, 27'h0123456};
      #1;
      check($sformatf("v%0d strobes", i), 32'(strobes_now()), 32'(vecs[i].strobes));
      check($sformatf("v%0d opcode", i), 32'(opcode), 32'(vecs[i].opc));
      check($sformatf("v%0d t_step", i), 32'(t_step), 32'(vecs[i].t));
      check($sformatf("v%0d busy", i), 32'(busy), 32'(vecs[i].busy));
      check($sformatf("v%0d illegal", i), 32'(illegal), 32'(vecs[i].ill));
      check($sformatf("v%0d retired", i), 32'(retired), 32'(vecs[i].ret));
      check($sformatf("v%0d retired_w2", i), 32'(retired2), 32'(vecs[i].ret[1:0]));
      check_inv($sformatf("v%0d", i));
      @(negedge clk);
    end

    // Five chained ldi instructions: the 2-bit counter reads 1,2,3,0,1.
    do_reset();
    IR  = {LDI, 27'h0};
    run = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      found = 1'b0;
      for (int c = 0; c < 20 && !found; c++) begin
        @(negedge clk);
        #1;
        if (t_step == 3'd5) found = 1'b1;
      end
      check($sformatf("wrap%0d reached_E5", k), 32'(found), 32'd1);
      if (k == 5) run = 1'b0;
      @(negedge clk);
      #1;
      check($sformatf("wrap%0d retired_w2", k), 32'(retired2), 32'(k % 4));
      check($sformatf("wrap%0d retired", k), 32'(retired), 32'(k));
      check($sformatf("wrap%0d t_step", k), 32'(t_step), 32'd0);
    end
    check("wrap final busy", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
